uart_tx_parity: RTL
===================

# uart_tx_parity

Serial transmitter for the UART link; the transmit-side counterpart of the receiver's parity checker. It accepts one byte per handshake and shifts out a fixed 11-bit frame: start bit, 8 data bits LSB first, even parity bit, one stop bit. The even parity bit equals the XOR of the 8 data bits, so the receiver's parity check passes on every uncorrupted frame. The block sits between the host-side byte source and the TX pad.

## Interface
- CLK_DIV, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  byte to transmit; sampled only on acceptance
- tx_start  input  1  request to send data_in; honoured only while tx_busy = 0
- tx_busy  output  1  high from the cycle after acceptance until the stop bit completes
- tx_done  output  1  one-cycle pulse marking frame completion
- tx_out  output  1  serial line; idles high

## Operation
- Registers:
  - state: IDLE, START, DATA, PARITY, STOP
  - baud counter: width clog2(CLK_DIV), counts 0..CLK_DIV-1
  - 3-bit bit index
  - 8-bit shift register
  - parity register
- IDLE:
  - tx_out = 1, tx_busy = 0.
  - If tx_start = 1, latch data_in into the shift register and latch ^data_in into the parity register.
  - Clear the baud counter and bit index, then go to START.
- START: tx_out = 0 for CLK_DIV cycles, then go to DATA.
- DATA:
  - tx_out = shift register bit 0.
  - When the baud counter = CLK_DIV-1, shift right and increment the bit index.
  - After the bit index reaches 7 and that bit completes, go to PARITY.
- PARITY: tx_out = parity register for CLK_DIV cycles, then go to STOP.
- STOP:
  - tx_out = 1 for CLK_DIV cycles.
  - On the last cycle, go to IDLE and set tx_done = 1 for the next cycle only.
- The baud counter wraps to 0 at CLK_DIV-1 in every non-IDLE state. The state advances only on that wrap.
- tx_start while tx_busy = 1 is ignored. The current frame and its latched data are unaffected, and a held request is not queued.
- Changes on data_in after acceptance have no effect on the frame in flight.
- tx_out, tx_busy and tx_done are registered outputs, with no combinational path from any input.

## Timing
- Reset values: tx_out = 1, tx_busy = 0, tx_done = 0, state = IDLE, counters = 0.
- Reset asserted mid-frame: on the next edge, outputs return to their reset values and the frame is abandoned. No tx_done is issued.
- Acceptance: tx_start = 1 sampled in IDLE at edge E.
  - From edge E, tx_out = 0 and tx_busy = 1.
- Bit k of the frame (k = 0 start, 1..8 data, 9 parity, 10 stop) occupies cycles E + k·CLK_DIV through E + (k+1)·CLK_DIV - 1.
- Frame length is exactly 11·CLK_DIV cycles.
- At edge E + 11·CLK_DIV:
  - tx_done = 1 and tx_busy = 0 for one cycle.
  - tx_start sampled at that same edge is accepted, giving zero idle gap.
  - Back-to-back frame period is therefore 11·CLK_DIV cycles.
- tx_done is never high while tx_busy is high.

## Test plan
All tests use CLK_DIV = 4.
- **Reset:** hold reset 3 cycles -> tx_out = 1, tx_busy = 0, tx_done = 0. Release reset with tx_start low for 20 cycles -> outputs unchanged.
- **Send 0x55:** pulse tx_start with data_in = 0x55 -> tx_out holds each of 0,1,0,1,0,1,0,1,0,0,1 for 4 cycles (parity 0). tx_done pulses exactly 44 cycles after acceptance.
- **Send 0x07:** -> data bits 1,1,1,0,0,0,0,0 and parity bit = 1. Receiver parity check reports no error.
- **Busy-ignore:** during a 0x55 frame, pulse tx_start with data_in = 0xFF at cycle 10 -> frame bits unchanged. Only one tx_done, and no second frame.
- **Back-to-back:** tx_start held high with data_in = 0xA3, then 0x3C -> two contiguous 44-cycle frames with no extra idle cycle. Parity bits are 0 and 0, with two tx_done pulses 44 cycles apart.
- **Reset mid-frame:** assert reset at cycle 20 of a frame -> tx_out = 1 and tx_busy = 0 on the next edge, with no tx_done. A new tx_start after release transmits a full, correct frame.

Source files
------------

// File: rtl/uart_tx_parity.sv
// UART transmitter: 11-bit frame (start, 8 data LSB first, even parity, stop)
// with registered outputs and zero-gap back-to-back acceptance at stop-bit end.
module uart_tx_parity #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_out,
    output logic [2:0] dbg_state_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          tx_out_q;
    logic          busy_q;
    logic          done_q;
    logic          baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        shift_q   <= data_in;
                        parity_q  <= ^data_in;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= START;
                        tx_out_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    // Busy may have been dropped for the tx_done cycle of a chained frame.
                    busy_q <= 1'b1;
                    if (baud_wrap) begin
                        state_q  <= DATA;
                        tx_out_q <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q  <= PARITY;
                            tx_out_q <= parity_q;
                        end else begin
                            tx_out_q <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_wrap) begin
                        state_q  <= STOP;
                        tx_out_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        // A request on the final stop cycle starts the next frame with no gap.
                        if (tx_start) begin
                            shift_q   <= data_in;
                            parity_q  <= ^data_in;
                            bit_idx_q <= '0;
                            state_q   <= START;
                            tx_out_q  <= 1'b0;
                        end else begin
                            state_q  <= IDLE;
                            tx_out_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out      = tx_out_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;

endmodule
